// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with in-order line refill over the
// memory controller's word-read handshake; ROB mispredictions abort refills.
module icache_ctrl #(
    parameter int INDEX_BITS  = 5,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetcher_flag,
    input  logic [31:0] in_fetcher_pc,
    output logic        out_fetcher_flag,
    output logic [31:0] out_fetcher_inst,
    output logic        out_mem_flag,
    output logic [31:0] out_mem_pc,
    input  logic        in_mem_flag,
    input  logic [31:0] in_mem_inst,
    input  logic        in_rob_xbp
);

    localparam int LO       = OFFSET_BITS + 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - LO;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [LINES-1:0]        valid_q, valid_d;
    logic [TAG_BITS-1:0]     tag_q [LINES];
    logic [31:0]             data_q [LINES*WORDS];
    logic [31-LO:0]          base_q, base_d;
    logic [OFFSET_BITS-1:0]  off_q, off_d;
    logic [OFFSET_BITS-1:0]  k_q, k_d;
    logic                    fflag_q, fflag_d;
    logic [31:0]             finst_q, finst_d;
    logic                    mflag_q, mflag_d;
    logic [31:0]             mpc_q, mpc_d;

    logic [INDEX_BITS-1:0]   req_index, fill_index;
    logic [TAG_BITS-1:0]     req_tag, fill_tag;
    logic [OFFSET_BITS-1:0]  req_off, k_inc;
    logic                    req_hit, data_we, tag_we;
    logic                    unused_pc_bits;

    assign req_index      = in_fetcher_pc[LO+INDEX_BITS-1:LO];
    assign req_tag        = in_fetcher_pc[31:LO+INDEX_BITS];
    assign req_off        = in_fetcher_pc[LO-1:2];
    assign fill_index     = base_q[INDEX_BITS-1:0];
    assign fill_tag       = base_q[31-LO:INDEX_BITS];
    assign req_hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign k_inc          = k_q + 1'b1;
    assign unused_pc_bits = ^in_fetcher_pc[1:0];

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        base_d  = base_q;
        off_d   = off_q;
        k_d     = k_q;
        fflag_d = 1'b0;
        finst_d = finst_q;
        mflag_d = mflag_q;
        mpc_d   = mpc_q;
        data_we = 1'b0;
        tag_we  = 1'b0;
        if (in_rob_xbp) begin
            state_d = IDLE;
            mflag_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fetcher_flag && !fflag_q) begin
                        if (req_hit) begin
                            fflag_d = 1'b1;
                            finst_d = data_q[{req_index, req_off}];
                        end else begin
                            valid_d[req_index] = 1'b0;
                            base_d  = in_fetcher_pc[31:LO];
                            off_d   = req_off;
                            k_d     = '0;
                            mflag_d = 1'b1;
                            mpc_d   = {in_fetcher_pc[31:LO], {LO{1'b0}}};
                            state_d = REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (in_mem_flag) begin
                        data_we = 1'b1;
                        if (k_q == OFFSET_BITS'(WORDS - 1)) begin
                            mflag_d             = 1'b0;
                            valid_d[fill_index] = 1'b1;
                            tag_we              = 1'b1;
                            fflag_d             = 1'b1;
                            // requested word may be the beat being written this cycle
                            finst_d = (off_q == k_q) ? in_mem_inst
                                                     : data_q[{fill_index, off_q}];
                            state_d = RESPOND;
                        end else begin
                            k_d   = k_inc;
                            mpc_d = {base_q, k_inc, 2'b00};
                        end
                    end
                end
                RESPOND: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            base_q  <= '0;
            off_q   <= '0;
            k_q     <= '0;
            fflag_q <= 1'b0;
            finst_q <= '0;
            mflag_q <= 1'b0;
            mpc_q   <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            valid_q <= valid_d;
            base_q  <= base_d;
            off_q   <= off_d;
            k_q     <= k_d;
            fflag_q <= fflag_d;
            finst_q <= finst_d;
            mflag_q <= mflag_d;
            mpc_q   <= mpc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy) begin
            if (data_we) data_q[{fill_index, k_q}] <= in_mem_inst;
            if (tag_we)  tag_q[fill_index] <= fill_tag;
        end
    end

    assign out_fetcher_flag = fflag_q;
    assign out_fetcher_inst = finst_q;
    assign out_mem_flag     = mflag_q;
    assign out_mem_pc       = mpc_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a memory model serves refill beats on demand;
// all inputs change and outputs are sampled on the falling clock edge.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        in_fetcher_flag = 1'b0;
    logic [31:0] in_fetcher_pc = '0;
    logic        out_fetcher_flag;
    logic [31:0] out_fetcher_inst;
    logic        out_mem_flag;
    logic [31:0] out_mem_pc;
    logic        in_mem_flag = 1'b0;
    logic [31:0] in_mem_inst = '0;
    logic        in_rob_xbp = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_ctrl #(.INDEX_BITS(5), .OFFSET_BITS(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetcher_flag(in_fetcher_flag), .in_fetcher_pc(in_fetcher_pc),
        .out_fetcher_flag(out_fetcher_flag), .out_fetcher_inst(out_fetcher_inst),
        .out_mem_flag(out_mem_flag), .out_mem_pc(out_mem_pc),
        .in_mem_flag(in_mem_flag), .in_mem_inst(in_mem_inst),
        .in_rob_xbp(in_rob_xbp)
    );

    // Word at byte address a: (line number << 8) + (word offset + 1) * 0x11
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {30'd0, a[3:2]} + 32'd1;
        return ((a >> 4) << 8) + w * 32'h11;
    endfunction

    // Waits (bounded) for a read request, answers it with a one-cycle pulse.
    task automatic beat(output logic [31:0] pc_seen, output bit ok);
        ok = 1'b0;
        pc_seen = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_mem_flag === 1'b1) begin
                pc_seen     = out_mem_pc;
                in_mem_flag = 1'b1;
                in_mem_inst = mem_word(out_mem_pc);
                ok          = 1'b1;
            end
        end
        if (ok) begin
            @(negedge clk);
            in_mem_flag = 1'b0;
        end
    endtask

    task automatic req(input logic [31:0] pc);
        @(negedge clk);
        in_fetcher_flag = 1'b1;
        in_fetcher_pc   = pc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_fetcher_flag, out_mem_flag, out_fetcher_inst, out_mem_pc} !== 66'd0) begin
            errors++;
            $display("FAIL reset: ff=%b mf=%b inst=%h mpc=%h, required all 0",
                     out_fetcher_flag, out_mem_flag, out_fetcher_inst, out_mem_pc);
        end
    endtask

    task automatic test_cold_miss;
        logic [31:0] pc;
        bit ok;
        req(32'h0);
        for (int i = 0; i < 4; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL cold_beat%0d: ok=%0d pc=%h, required pc=%h", i, ok, pc, 32'(4 * i));
            end
        end
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h11 || out_mem_flag !== 1'b0) begin
            errors++;
            $display("FAIL cold_resp: ff=%b inst=%h mf=%b, required 1/00000011/0",
                     out_fetcher_flag, out_fetcher_inst, out_mem_flag);
        end
        in_fetcher_flag = 1'b0;
        @(negedge clk);
        checks++;
        if (out_fetcher_flag !== 1'b0 || out_mem_flag !== 1'b0) begin
            errors++;
            $display("FAIL cold_after: ff=%b mf=%b, required 0/0", out_fetcher_flag, out_mem_flag);
        end
    endtask

    task automatic test_hit_back_to_back;
        req(32'h8);
        @(negedge clk);
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h33 || out_mem_flag !== 1'b0) begin
            errors++;
            $display("FAIL hit_8: ff=%b inst=%h mf=%b, required 1/00000033/0",
                     out_fetcher_flag, out_fetcher_inst, out_mem_flag);
        end
        in_fetcher_pc = 32'hC;
        @(negedge clk);
        checks++;
        if (out_fetcher_flag !== 1'b0) begin
            errors++;
            $display("FAIL hit_gap: ff=%b, required 0", out_fetcher_flag);
        end
        @(negedge clk);
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h44 || out_mem_flag !== 1'b0) begin
            errors++;
            $display("FAIL hit_c: ff=%b inst=%h mf=%b, required 1/00000044/0",
                     out_fetcher_flag, out_fetcher_inst, out_mem_flag);
        end
        in_fetcher_flag = 1'b0;
        @(negedge clk);
        checks++;
        if (out_fetcher_flag !== 1'b0) begin
            errors++;
            $display("FAIL hit_single_pulse: ff=%b, required 0", out_fetcher_flag);
        end
    endtask

    task automatic test_conflict;
        logic [31:0] pc;
        bit ok;
        req(32'h204);
        for (int i = 0; i < 4; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'h200 + 32'(4 * i)) begin
                errors++;
                $display("FAIL conflict_beat%0d: ok=%0d pc=%h, required pc=%h",
                         i, ok, pc, 32'h200 + 32'(4 * i));
            end
        end
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h2022) begin
            errors++;
            $display("FAIL conflict_resp: ff=%b inst=%h, required 1/00002022",
                     out_fetcher_flag, out_fetcher_inst);
        end
        in_fetcher_flag = 1'b0;
        req(32'h0);
        for (int i = 0; i < 4; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL evicted_beat%0d: ok=%0d pc=%h, required pc=%h", i, ok, pc, 32'(4 * i));
            end
        end
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h11) begin
            errors++;
            $display("FAIL evicted_resp: ff=%b inst=%h, required 1/00000011",
                     out_fetcher_flag, out_fetcher_inst);
        end
        in_fetcher_flag = 1'b0;
    endtask

    task automatic test_flush;
        logic [31:0] pc;
        bit ok;
        // hit request coinciding with a flush is dropped
        @(negedge clk);
        in_fetcher_flag = 1'b1;
        in_fetcher_pc   = 32'h8;
        in_rob_xbp      = 1'b1;
        @(negedge clk);
        in_rob_xbp      = 1'b0;
        in_fetcher_flag = 1'b0;
        checks++;
        if (out_fetcher_flag !== 1'b0) begin
            errors++;
            $display("FAIL flush_hit: ff=%b, required 0", out_fetcher_flag);
        end
        req(32'h40);
        for (int i = 0; i < 2; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'h40 + 32'(4 * i)) begin
                errors++;
                $display("FAIL flush_beat%0d: ok=%0d pc=%h, required pc=%h",
                         i, ok, pc, 32'h40 + 32'(4 * i));
            end
        end
        in_rob_xbp    = 1'b1;
        in_fetcher_pc = 32'h8;
        @(negedge clk);
        in_rob_xbp      = 1'b0;
        in_fetcher_flag = 1'b0;
        checks++;
        if (out_mem_flag !== 1'b0 || out_fetcher_flag !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort: mf=%b ff=%b, required 0/0", out_mem_flag, out_fetcher_flag);
        end
        in_mem_flag = 1'b1;
        in_mem_inst = 32'hDEADBEEF;
        @(negedge clk);
        in_mem_flag = 1'b0;
        @(negedge clk);
        checks++;
        if (out_mem_flag !== 1'b0 || out_fetcher_flag !== 1'b0) begin
            errors++;
            $display("FAIL flush_stray: mf=%b ff=%b, required 0/0", out_mem_flag, out_fetcher_flag);
        end
        req(32'h44);
        for (int i = 0; i < 4; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'h40 + 32'(4 * i)) begin
                errors++;
                $display("FAIL reflush_beat%0d: ok=%0d pc=%h, required pc=%h",
                         i, ok, pc, 32'h40 + 32'(4 * i));
            end
        end
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h422) begin
            errors++;
            $display("FAIL reflush_resp: ff=%b inst=%h, required 1/00000422",
                     out_fetcher_flag, out_fetcher_inst);
        end
        in_fetcher_flag = 1'b0;
    endtask

    task automatic test_rdy_freeze;
        logic [31:0] pc;
        bit ok;
        req(32'h84);
        for (int i = 0; i < 2; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'h80 + 32'(4 * i)) begin
                errors++;
                $display("FAIL freeze_beat%0d: ok=%0d pc=%h, required pc=%h",
                         i, ok, pc, 32'h80 + 32'(4 * i));
            end
        end
        rdy         = 1'b0;
        in_mem_flag = 1'b1;
        in_mem_inst = mem_word(32'h88);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_mem_flag !== 1'b1 || out_mem_pc !== 32'h88 || out_fetcher_flag !== 1'b0) begin
                errors++;
                $display("FAIL freeze_refill%0d: mf=%b mpc=%h ff=%b, required 1/00000088/0",
                         i, out_mem_flag, out_mem_pc, out_fetcher_flag);
            end
        end
        rdy = 1'b1;
        @(negedge clk);
        in_mem_flag = 1'b0;
        checks++;
        if (out_mem_flag !== 1'b1 || out_mem_pc !== 32'h8C) begin
            errors++;
            $display("FAIL freeze_resume: mf=%b mpc=%h, required 1/0000008c", out_mem_flag, out_mem_pc);
        end
        beat(pc, ok);
        checks++;
        if (!ok || pc !== 32'h8C) begin
            errors++;
            $display("FAIL freeze_beat3: ok=%0d pc=%h, required pc=0000008c", ok, pc);
        end
        in_fetcher_flag = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'h822 || out_mem_flag !== 1'b0) begin
                errors++;
                $display("FAIL freeze_resp%0d: ff=%b inst=%h mf=%b, required 1/00000822/0",
                         i, out_fetcher_flag, out_fetcher_inst, out_mem_flag);
            end
            if (i < 5) @(negedge clk);
        end
        rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_fetcher_flag !== 1'b0 || out_mem_flag !== 1'b0) begin
                errors++;
                $display("FAIL freeze_after%0d: ff=%b mf=%b, required 0/0",
                         i, out_fetcher_flag, out_mem_flag);
            end
        end
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0] pc;
        bit ok;
        req(32'hC0);
        beat(pc, ok);
        checks++;
        if (!ok || pc !== 32'hC0) begin
            errors++;
            $display("FAIL rstmid_beat0: ok=%0d pc=%h, required pc=000000c0", ok, pc);
        end
        rst             = 1'b1;
        in_mem_flag     = 1'b1;
        in_mem_inst     = mem_word(32'hC4);
        in_fetcher_flag = 1'b0;
        @(negedge clk);
        rst         = 1'b0;
        in_mem_flag = 1'b0;
        checks++;
        if ({out_fetcher_flag, out_mem_flag, out_fetcher_inst, out_mem_pc} !== 66'd0) begin
            errors++;
            $display("FAIL rstmid_outputs: ff=%b mf=%b inst=%h mpc=%h, required all 0",
                     out_fetcher_flag, out_mem_flag, out_fetcher_inst, out_mem_pc);
        end
        req(32'hC0);
        for (int i = 0; i < 4; i++) begin
            beat(pc, ok);
            checks++;
            if (!ok || pc !== 32'hC0 + 32'(4 * i)) begin
                errors++;
                $display("FAIL rstmid_rebeat%0d: ok=%0d pc=%h, required pc=%h",
                         i, ok, pc, 32'hC0 + 32'(4 * i));
            end
        end
        checks++;
        if (out_fetcher_flag !== 1'b1 || out_fetcher_inst !== 32'hC11) begin
            errors++;
            $display("FAIL rstmid_resp: ff=%b inst=%h, required 1/00000c11",
                     out_fetcher_flag, out_fetcher_inst);
        end
        in_fetcher_flag = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_hit_back_to_back;
        test_conflict;
        test_flush;
        test_rdy_freeze;
        test_reset_mid_refill;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
